// File: rtl/pet_action_scheduler_if.sv
// Action offer handshake between pet_action_scheduler (master) and game_state (slave).
interface pet_action_scheduler_if;
    logic       act_valid;
    logic       act_ready;
    logic [1:0] act_code;

    modport master (output act_valid, output act_code, input act_ready);
    modport slave  (input act_valid, input act_code, output act_ready);
endinterface

// File: rtl/pet_action_scheduler.sv
// Maps keycode presses to one-shot pet actions and frame-timed decay events with per-action cooldown.
// Optional macro PET_SCHED_STATS_EN adds a saturating drop_cnt output.
module pet_action_scheduler #(
    parameter int unsigned COOLDOWN_FRAMES = 60,
    parameter int unsigned DECAY_FRAMES    = 120,
    parameter logic [7:0]  KEY_FEED        = 8'h09,
    parameter logic [7:0]  KEY_PLAY        = 8'h13,
    parameter logic [7:0]  KEY_HEAL        = 8'h0B
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   vs,
    input  logic [7:0]             keycode,
    pet_action_scheduler_if.master act,
`ifdef PET_SCHED_STATS_EN
    output logic [7:0]             drop_cnt,
`endif
    output logic                   busy,
    output logic                   frame_tick
);
    typedef enum logic [1:0] {IDLE, OFFER_ACT, OFFER_DECAY, COOLDOWN} state_t;

    state_t     state;
    logic       vs_q;
    logic [7:0] key_q;
    logic [9:0] decay_cnt;
    logic       decay_pend;
    logic [7:0] cd_cnt;
    logic       slot_valid;
    logic [1:0] slot_code;
    logic       valid_q;
    logic [1:0] code_q;

    logic       key_hit;
    logic [1:0] press_code;
    logic       press;
    logic       wrap;
    logic       lost;
    logic       xfer;

    assign frame_tick = vs & ~vs_q;
    assign act.act_valid = valid_q;
    assign act.act_code  = code_q;

    always_comb begin
        key_hit    = 1'b1;
        press_code = 2'b00;
        if (keycode == KEY_FEED)      press_code = 2'b01;
        else if (keycode == KEY_PLAY) press_code = 2'b10;
        else if (keycode == KEY_HEAL) press_code = 2'b11;
        else                          key_hit    = 1'b0;
    end

    assign press = key_hit && (keycode != key_q);
    assign wrap  = frame_tick && (decay_cnt == 10'(DECAY_FRAMES - 1));
    assign lost  = wrap && decay_pend;
    assign xfer  = valid_q && act.act_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            vs_q       <= 1'b1;
            key_q      <= '0;
            decay_cnt  <= '0;
            decay_pend <= 1'b0;
            cd_cnt     <= '0;
            slot_valid <= 1'b0;
            slot_code  <= '0;
            valid_q    <= 1'b0;
            code_q     <= '0;
            busy       <= 1'b0;
        end else begin
            vs_q  <= vs;
            key_q <= keycode;
            if (frame_tick)
                decay_cnt <= wrap ? '0 : decay_cnt + 10'd1;
            // A wrap coinciding with a decay transfer is lost: it found the flag still set.
            if (state == OFFER_DECAY && xfer)
                decay_pend <= 1'b0;
            if (wrap && !decay_pend)
                decay_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (press) begin
                        state      <= OFFER_ACT;
                        valid_q    <= 1'b1;
                        code_q     <= press_code;
                        slot_valid <= 1'b0;
                    end else if (slot_valid) begin
                        state      <= OFFER_ACT;
                        valid_q    <= 1'b1;
                        code_q     <= slot_code;
                        slot_valid <= 1'b0;
                    end else if (decay_pend) begin
                        state   <= OFFER_DECAY;
                        valid_q <= 1'b1;
                        code_q  <= 2'b00;
                    end
                end
                OFFER_ACT: begin
                    if (xfer) begin
                        valid_q <= 1'b0;
                        if (COOLDOWN_FRAMES == 0) begin
                            state <= IDLE;
                        end else begin
                            state  <= COOLDOWN;
                            busy   <= 1'b1;
                            cd_cnt <= 8'(COOLDOWN_FRAMES);
                        end
                    end
                end
                OFFER_DECAY: begin
                    if (press) begin
                        slot_valid <= 1'b1;
                        slot_code  <= press_code;
                    end
                    if (xfer) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == 8'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (frame_tick) begin
                        cd_cnt <= cd_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PET_SCHED_STATS_EN
    logic       press_drop;
    logic [8:0] drop_sum;

    // An overwritten slot counts as a dropped press, whether the newcomer lands in the slot or in IDLE.
    assign press_drop = press && ((state == OFFER_ACT) || (state == COOLDOWN) ||
                                  (((state == IDLE) || (state == OFFER_DECAY)) && slot_valid));
    assign drop_sum   = {1'b0, drop_cnt} + {8'd0, press_drop} + {8'd0, lost};

    always_ff @(posedge Clk) begin
        if (Reset)
            drop_cnt <= '0;
        else
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
`endif
endmodule
